whistle_pwm_out: RTL

Output stage of the whistle audio path. Consumes the 8-bit offset-binary sine samples and the enable produced by the upstream sine generator and drives a single-bit PWM to the board audio amplifier. A gain-ramp state machine fades the signal in and out around midscale (128), which avoids pops on start and stop. It also drives the amplifier shutdown pin.

---
 rtl/whistle_pkg.sv | 15 +
 rtl/pwm_core.sv | 23 ++
 rtl/whistle_pwm_out.sv | 79 +++++++
 3 files changed

// File: rtl/whistle_pkg.sv
// whistle_pkg: FSM encodings, scaling constants and the gain-scaled duty function for the whistle PWM stage.
package whistle_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DOWN = 2'd3} state_e;
  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam logic [4:0] GAIN_MAX = 5'd16;
  localparam int GAIN_SHIFT = 4;
  // 128 + floor((s-128)*g/16); the result always lands in 0..255 for g <= 16
  function automatic logic [7:0] duty_calc(input logic [7:0] s, input logic [4:0] g);
    logic signed [13:0] d, p;
    d = $signed({6'b0, s}) - $signed({6'b0, MIDSCALE});
    p = (d * $signed({9'b0, g})) >>> GAIN_SHIFT;
    p = p + $signed({6'b0, MIDSCALE});
    return p[7:0];
  endfunction
endpackage

// File: rtl/pwm_core.sv
// pwm_core: free-running period counter with boundary flag and registered duty comparator.
module pwm_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] duty,
  output logic         bnd,
  output logic         pwm
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pwm   <= 1'b0;
    end else begin
      cnt_q <= run ? cnt_q + 1'b1 : '0;
      pwm   <= run && (cnt_q < duty);
    end
  end
  assign bnd = cnt_q == '1;
endmodule

// File: rtl/whistle_pwm_out.sv
// whistle_pwm_out: sample buffering, gain ramp FSM and duty scaling feeding the PWM core; drives amp shutdown.
module whistle_pwm_out
  import whistle_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int GAIN_BITS = 5,
  parameter int RAMP_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sample_in,
  input  logic       sample_stb,
  output logic       pwm_out,
  output logic       sd_n,
  output logic       busy,
  output logic [1:0] state
);
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  localparam logic [GAIN_BITS-1:0] GMAX = GAIN_BITS'(GAIN_MAX);
  localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  state_e state_q, state_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic [7:0] ramp_q, ramp_d, pending_q, active_q, a_d;
  logic [PWM_BITS-1:0] duty_q;
  logic pend_valid_q, bnd, ramping, wrap;
  assign ramping = state_q == RAMP_UP || state_q == RAMP_DOWN;
  assign wrap = bnd && ramping && ramp_q == RAMP_LAST;
  assign a_d = pend_valid_q ? pending_q : active_q;
  always_comb begin
    ramp_d = state_q == OFF ? '0 : (bnd && ramping) ? (wrap ? '0 : ramp_q + 1'b1) : ramp_q;
    gain_d = state_q == OFF ? '0 : !wrap ? gain_q :
             state_q == RAMP_UP ? (gain_q == GMAX ? gain_q : gain_q + 1'b1) :
             (gain_q == '0 ? gain_q : gain_q - 1'b1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gain_q       <= '0;
      ramp_q       <= '0;
      pending_q    <= MIDSCALE;
      pend_valid_q <= 1'b0;
      active_q     <= MIDSCALE;
      duty_q       <= MID;
    end else begin
      gain_q       <= gain_d;
      ramp_q       <= ramp_d;
      pending_q    <= sample_stb ? sample_in : pending_q;
      pend_valid_q <= sample_stb || (pend_valid_q && !bnd);
      active_q     <= bnd ? a_d : active_q;
      duty_q       <= bnd ? PWM_BITS'(duty_calc(a_d, 5'(gain_d))) : duty_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OFF;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:       state_d = en ? RAMP_UP : OFF;
      RAMP_UP:   state_d = !en ? RAMP_DOWN : (bnd && gain_d == GMAX) ? RUN : RAMP_UP;
      RUN:       state_d = en ? RUN : RAMP_DOWN;
      RAMP_DOWN: state_d = (bnd && gain_d == '0) ? OFF : en ? RAMP_UP : RAMP_DOWN;
    endcase
  end
  always_comb begin
    sd_n  = state_q != OFF;
    busy  = state_q != OFF;
    state = state_q;
  end
  pwm_core #(.W(PWM_BITS)) u_core (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q != OFF),
    .duty (duty_q),
    .bnd  (bnd),
    .pwm  (pwm_out)
  );
endmodule
